// File: rtl/fp32_pkg.sv
// Shared FP32 arithmetic definitions: field widths, encodings, operand struct and
// the divider state type.
package fp32_pkg;

  localparam int unsigned FP_EXP_W = 8;
  localparam int unsigned FP_MAN_W = 23;
  localparam int unsigned FP_BIAS  = 127;
  localparam int unsigned FP_QBITS = 26;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] man;
  } fp32_t;

  typedef enum logic [1:0] {
    IDLE,
    DIVIDE,
    NORM,
    DONE
  } div_state_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 operand classifier (flush-to-zero: any exp==0 is zero).
// Ports:
//   op       in  fp32_t  operand
//   is_zero  out 1       exponent field all zeros
//   is_inf   out 1       exponent all ones, mantissa zero
//   is_nan   out 1       exponent all ones, mantissa non-zero
module fp32_classify
  import fp32_pkg::*;
(
  input  fp32_t op,
  output logic  is_zero,
  output logic  is_inf,
  output logic  is_nan
);

  always_comb begin
    is_zero = (op.exp == '0);
    is_inf  = (op.exp == '1) && (op.man == '0);
    is_nan  = (op.exp == '1) && (op.man != '0);
  end

endmodule

// File: rtl/fp32_divider.sv
// Sequential FP32 divider, result = a / b. Restoring mantissa division producing one
// quotient bit per clock, one operation in flight, flush-to-zero.
// Optional feature macro: FP32_DIV_ROUND_EN enables round-to-nearest-even;
// without it the quotient is truncated.
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operands valid
//   in_ready   out  1   divider idle, can accept
//   a          in   32  dividend
//   b          in   32  divisor
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   result     out  32  quotient
module fp32_divider
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int unsigned EXP_W = FP_EXP_W;
  localparam int unsigned MAN_W = FP_MAN_W;
  localparam int unsigned BIAS  = FP_BIAS;
  localparam int unsigned QBITS = FP_QBITS;
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned REM_W = SIG_W + 1;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned E_W   = 10;

  fp32_t op_a;
  fp32_t op_b;
  assign op_a = fp32_t'(a);
  assign op_b = fp32_t'(b);

  logic zero_a, inf_a, nan_a;
  logic zero_b, inf_b, nan_b;

  fp32_classify u_class_a (.op(op_a), .is_zero(zero_a), .is_inf(inf_a), .is_nan(nan_a));
  fp32_classify u_class_b (.op(op_b), .is_zero(zero_b), .is_inf(inf_b), .is_nan(nan_b));

  div_state_t               state;
  logic [CNT_W-1:0]         cnt;
  logic [REM_W-1:0]         rem;
  logic [QBITS-1:0]         q;
  logic [SIG_W-1:0]         divisor;
  logic signed [E_W-1:0]    e_r;
  logic                     sign_r;

  // Special-operand detection, highest priority first.
  logic        sign_c;
  logic        special_c;
  logic [31:0] special_res_c;

  always_comb begin
    sign_c        = op_a.sign ^ op_b.sign;
    special_c     = 1'b1;
    special_res_c = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      special_res_c = FP_QNAN;
    end else if (zero_b || inf_a) begin
      special_res_c = {sign_c, FP_POS_INF[30:0]};
    end else if (zero_a || inf_b) begin
      special_res_c = {sign_c, 31'b0};
    end else begin
      special_c = 1'b0;
    end
  end

  // One restoring-division step; the first step uses the loaded dividend unshifted.
  logic [REM_W-1:0] rem_cur_c;
  logic [REM_W-1:0] rem_nxt_c;
  logic             qbit_c;

  always_comb begin
    rem_cur_c = (cnt == '0) ? rem : {rem[REM_W-2:0], 1'b0};
    qbit_c    = (rem_cur_c >= {1'b0, divisor});
    rem_nxt_c = qbit_c ? (rem_cur_c - {1'b0, divisor}) : rem_cur_c;
  end

  // Normalisation, optional rounding and exponent range check.
  logic [MAN_W-1:0]      man_c;
  logic [MAN_W-1:0]      man_fin_c;
  logic signed [E_W-1:0] e_norm_c;
  logic signed [E_W-1:0] e_fin_c;
  logic [31:0]           norm_res_c;

`ifdef FP32_DIV_ROUND_EN
  logic             guard_c;
  logic             sticky_c;
  logic             inc_c;
  logic [SIG_W-1:0] man_inc_c;

  always_comb begin
    if (q[QBITS-1]) begin
      man_c    = q[QBITS-2:2];
      guard_c  = q[1];
      sticky_c = q[0] | (rem != '0);
      e_norm_c = e_r;
    end else begin
      man_c    = q[QBITS-3:1];
      guard_c  = q[0];
      sticky_c = (rem != '0);
      e_norm_c = e_r - E_W'(1);
    end
    inc_c     = guard_c & (sticky_c | man_c[0]);
    man_inc_c = {1'b0, man_c} + SIG_W'(inc_c);
    // Mantissa carry-out: significand becomes 2.0, renormalise into the exponent.
    if (man_inc_c[MAN_W]) begin
      man_fin_c = '0;
      e_fin_c   = e_norm_c + E_W'(1);
    end else begin
      man_fin_c = man_inc_c[MAN_W-1:0];
      e_fin_c   = e_norm_c;
    end
  end
`else
  logic unused_trunc_c;

  always_comb begin
    if (q[QBITS-1]) begin
      man_c    = q[QBITS-2:2];
      e_norm_c = e_r;
    end else begin
      man_c    = q[QBITS-3:1];
      e_norm_c = e_r - E_W'(1);
    end
    man_fin_c = man_c;
    e_fin_c   = e_norm_c;
  end

  // Guard/sticky bits are discarded when truncating.
  assign unused_trunc_c = q[0];
`endif

  always_comb begin
    if (e_fin_c >= E_W'(255)) begin
      norm_res_c = {sign_r, FP_POS_INF[30:0]};
    end else if (e_fin_c <= 10'sd0) begin
      norm_res_c = {sign_r, 31'b0};
    end else begin
      norm_res_c = {sign_r, e_fin_c[EXP_W-1:0], man_fin_c};
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      divisor   <= '0;
      e_r       <= '0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            sign_r   <= sign_c;
            if (special_c) begin
              result    <= special_res_c;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              rem     <= {1'b0, 1'b1, op_a.man};
              divisor <= {1'b1, op_b.man};
              q       <= '0;
              cnt     <= '0;
              e_r     <= $signed({2'b00, op_a.exp}) - $signed({2'b00, op_b.exp})
                         + $signed(E_W'(BIAS));
              state   <= DIVIDE;
            end
          end
        end
        DIVIDE: begin
          rem <= rem_nxt_c;
          q   <= {q[QBITS-2:0], qbit_c};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(QBITS - 1)) begin
            state <= NORM;
          end
        end
        NORM: begin
          result    <= norm_res_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_divider.sv
// Testbench for fp32_divider: directed cases plus randomized operands checked
// against an arithmetic reference model.
module tb_fp32_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fp32_divider dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [31:0] x, input logic [31:0] y);
    return (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
  endfunction

  // Reference: exact integer division of the significands, then IEEE packing.
  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    logic              s;
    logic [7:0]        ea, eb;
    logic [22:0]       ma, mb;
    bit                za, zb, ia, ib, na, nb;
    longint unsigned   num, den, qq, rr, man, g, st;
    int                e;
    logic [7:0]        e8;
    logic [22:0]       m23;
    s  = x[31] ^ y[31];
    ea = x[30:23]; eb = y[30:23];
    ma = x[22:0];  mb = y[22:0];
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 8'hFF) && (ma == 0); ib = (eb == 8'hFF) && (mb == 0);
    na = (ea == 8'hFF) && (ma != 0); nb = (eb == 8'hFF) && (mb != 0);
    if (na || nb || (za && zb) || (ia && ib)) return 32'h7FC00000;
    if (zb || ia) return {s, 31'h7F800000};
    if (za || ib) return {s, 31'h0};
    num = (longint'(ma) + 64'd8388608) << 25;
    den = longint'(mb) + 64'd8388608;
    qq  = num / den;
    rr  = num % den;
    e   = int'(ea) - int'(eb) + 127;
    if (qq >= 64'd33554432) begin
      man = (qq >> 2) & 64'h7FFFFF;
      g   = (qq >> 1) & 1;
      st  = ((qq & 1) != 0 || rr != 0) ? 1 : 0;
    end else begin
      man = (qq >> 1) & 64'h7FFFFF;
      g   = qq & 1;
      st  = (rr != 0) ? 1 : 0;
      e   = e - 1;
    end
`ifdef FP32_DIV_ROUND_EN
    if (g == 1 && (st == 1 || (man & 1) == 1)) begin
      man = man + 1;
      if (man == 64'd8388608) begin
        man = 0;
        e   = e + 1;
      end
    end
`else
    g  = g + st;  // rounding information is dropped when truncating
`endif
    if (e >= 255) return {s, 31'h7F800000};
    if (e <= 0) return {s, 31'h0};
    e8  = 8'(e);
    m23 = 23'(man);
    return {s, e8, m23};
  endfunction

  // Full transaction: present, wait accept, wait result, handshake it out.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output int lat);
    int g;
    a = av; b = bv; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_check(input string tag, input logic [31:0] av, input logic [31:0] bv);
    logic [31:0] res;
    int          lat;
    run_op(av, bv, res, lat);
    check({tag, " res"}, res, ref_div(av, bv));
    check({tag, " lat"}, 32'(lat), is_special(av, bv) ? 32'd1 : 32'd28);
    check({tag, " ov_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, av, bv;
    int          lat, r, g;
    bit          saw_ov;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed values with hand-derived expectations.
    run_op(32'h40C00000, 32'h40000000, res, lat);
    check("6/2 res", res, 32'h40400000);
    check("6/2 lat", 32'(lat), 32'd28);
    run_op(32'h3F800000, 32'h40400000, res, lat);
`ifdef FP32_DIV_ROUND_EN
    check("1/3 res", res, 32'h3EAAAAAB);
`else
    check("1/3 res", res, 32'h3EAAAAAA);
`endif
    run_op(32'hC1000000, 32'h00000000, res, lat);
    check("-8/0 res", res, 32'hFF800000);
    check("-8/0 lat", 32'(lat), 32'd1);
    run_op(32'h00000000, 32'h00000000, res, lat);
    check("0/0 res", res, 32'h7FC00000);
    run_op(32'h00000000, 32'h40000000, res, lat);
    check("0/2 res", res, 32'h00000000);
    run_op(32'h7F000000, 32'h00800000, res, lat);
    check("ovf res", res, 32'h7F800000);
    run_op(32'h00800000, 32'h7F000000, res, lat);
    check("unf res", res, 32'h00000000);
    run_op(32'h7F800000, 32'h7F800000, res, lat);
    check("inf/inf res", res, 32'h7FC00000);
    run_op(32'h7F800000, 32'hC0000000, res, lat);
    check("inf/-2 res", res, 32'hFF800000);
    run_op(32'h40000000, 32'h7FC00001, res, lat);
    check("2/nan res", res, 32'h7FC00000);

    // Backpressure: result held while out_ready is low, new requests ignored.
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1; g++;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = $urandom; b = 32'h3F800000;
      @(posedge clk); #1;
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold result", result, 32'h40400000);
      check("hold in_ready", 32'(in_ready), 32'd0);
    end
    a = 32'h41200000; b = 32'h40A00000;
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain in_ready", 32'(in_ready), 32'd1);
    check("drain out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("next accepted", 32'(in_ready), 32'd0);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1; g++;
    end
    check("10/5 res", result, 32'h40000000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a division.
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort result", result, 32'h0);
    #3;
    rst_n = 1'b1;
    saw_ov = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) saw_ov = 1'b1;
    end
    check("abort no stale", 32'(saw_ov), 32'd0);
    run_op(32'h40C00000, 32'h40000000, res, lat);
    check("post-rst 6/2", res, 32'h40400000);

    // Randomized operands across normal, special and range-limit cases.
    for (int i = 0; i < 60; i++) begin
      av = $urandom; bv = $urandom;
      r  = $urandom_range(0, 9);
      case (r)
        0: av[30:23] = 8'h00;
        1: bv[30:23] = 8'h00;
        2: av[30:23] = 8'hFF;
        3: bv[30:23] = 8'hFF;
        4: bv[22:0]  = 23'h0;
        default: begin
          av[30:23] = 8'(110 + $urandom_range(0, 30));
          bv[30:23] = 8'(110 + $urandom_range(0, 30));
        end
      endcase
      do_check($sformatf("rnd%0d %h/%h", i, av, bv), av, bv);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
